// File: rtl/johnson_phase_decoder.sv
// -----------------------------------------------------------------------------
// johnson_phase_decoder
//
// Consumer of a WIDTH-bit Johnson counter. Each valid sample is checked for
// legality and for being a hold or +1 successor of the previous phase. Legal
// samples are decoded to a phase index and a one-hot phase vector, and
// completed rotations are counted. An illegal code drives the upstream
// counter's active-low preset (resync_n) for RESYNC_CYC cycles, with load_val
// tied to zero, and then decoding restarts from SYNC.
//
// Optional build macro: JOHNSON_DEC_STATS_EN
//   defined   : err_cnt counts illegal and step_err pulses, saturating at 255
//   undefined : err_cnt is constant 0 and no counter is built
//
// Ports:
//   clk          in   rising-edge clock
//   clear        in   synchronous active-high reset, highest priority
//   cnt_in       in   [WIDTH]            Johnson code from upstream
//   cnt_valid    in                      cnt_in meaningful this cycle
//   phase_idx    out  [clog2(2*WIDTH)]   decoded phase 0..2*WIDTH-1
//   phase_onehot out  [2*WIDTH]          bit phase_idx set when phase_valid
//   phase_valid  out                     phase outputs valid
//   illegal      out                     1-cycle pulse, non-Johnson code seen
//   step_err     out                     1-cycle pulse, legal but not hold/+1
//   cycle_cnt    out  [CYC_W]            completed rotations, wrapping
//   resync_n     out                     active-low preset request upstream
//   load_val     out  [WIDTH]            constant 0 load value upstream
//   err_cnt      out  [8]                error statistics (see macro above)
// -----------------------------------------------------------------------------
module johnson_phase_decoder #(
  parameter int WIDTH      = 4,
  parameter int CYC_W      = 8,
  parameter int RESYNC_CYC = 2
) (
  input  logic                         clk,
  input  logic                         clear,
  input  logic [WIDTH-1:0]             cnt_in,
  input  logic                         cnt_valid,
  output logic [$clog2(2*WIDTH)-1:0]   phase_idx,
  output logic [2*WIDTH-1:0]           phase_onehot,
  output logic                         phase_valid,
  output logic                         illegal,
  output logic                         step_err,
  output logic [CYC_W-1:0]             cycle_cnt,
  output logic                         resync_n,
  output logic [WIDTH-1:0]             load_val,
  output logic [7:0]                   err_cnt
);

  localparam int PH    = 2 * WIDTH;
  localparam int IDX_W = $clog2(PH);
  localparam int FC_W  = (RESYNC_CYC > 1) ? $clog2(RESYNC_CYC) : 1;

  typedef enum logic [1:0] {SYNC, TRACK, FAULT} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               ill_q, ill_d;
  logic               se_q, se_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic               rs_q, rs_d;
  logic [FC_W-1:0]    fcnt_q, fcnt_d;   // resync cycles still to go after this one

  // ---------------------------------------------------------------------------
  // Code classification
  // ---------------------------------------------------------------------------
  function automatic int popcount(input logic [WIDTH-1:0] c);
    int n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) n += int'(c[i]);
    return n;
  endfunction

  logic [WIDTH-1:0] ones;
  logic             code_legal;
  logic [IDX_W-1:0] code_idx;
  logic [IDX_W-1:0] succ_idx;
  int               n_ones;

  always_comb begin
    ones   = '1;
    n_ones = popcount(cnt_in);
    // A legal code is n ones packed against the MSB or against the LSB;
    // all-zeros and all-ones fall out of both masks naturally.
    code_legal = (cnt_in == ~(ones >> n_ones)) || (cnt_in == ~(ones << n_ones));
    // MSB set (or all zeros) means the filling half of the rotation.
    if (cnt_in[WIDTH-1] || n_ones == 0) code_idx = IDX_W'(n_ones);
    else                                code_idx = IDX_W'(PH - n_ones);
    succ_idx = (idx_q == IDX_W'(PH - 1)) ? '0 : idx_q + IDX_W'(1);
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= SYNC;
      idx_q   <= '0;
      valid_q <= 1'b0;
      ill_q   <= 1'b0;
      se_q    <= 1'b0;
      cyc_q   <= '0;
      rs_q    <= 1'b1;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      ill_q   <= ill_d;
      se_q    <= se_d;
      cyc_q   <= cyc_d;
      rs_q    <= rs_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default up front so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    ill_d   = 1'b0;
    se_d    = 1'b0;
    cyc_d   = cyc_q;
    rs_d    = rs_q;
    fcnt_d  = fcnt_q;

    unique case (state_q)
      SYNC, TRACK: begin
        if (cnt_valid) begin
          if (!code_legal) begin
            state_d = FAULT;
            ill_d   = 1'b1;
            valid_d = 1'b0;
            rs_d    = 1'b0;
            fcnt_d  = FC_W'(RESYNC_CYC - 1);
          end else if (state_q == SYNC) begin
            state_d = TRACK;
            idx_d   = code_idx;
            valid_d = 1'b1;
          end else if (code_idx == succ_idx) begin
            if (idx_q == IDX_W'(PH - 1)) cyc_d = cyc_q + CYC_W'(1);
            idx_d = code_idx;
          end else if (code_idx != idx_q) begin
            se_d  = 1'b1;
            idx_d = code_idx;
          end
        end
      end
      FAULT: begin
        // Window length is time-based: samples and cnt_valid are ignored.
        if (fcnt_q == '0) begin
          state_d = SYNC;
          rs_d    = 1'b1;
        end else begin
          fcnt_d = fcnt_q - FC_W'(1);
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    phase_idx    = idx_q;
    phase_valid  = valid_q;
    phase_onehot = valid_q ? (PH'(1) << idx_q) : '0;
    illegal      = ill_q;
    step_err     = se_q;
    cycle_cnt    = cyc_q;
    resync_n     = rs_q;
    load_val     = '0;
  end

`ifdef JOHNSON_DEC_STATS_EN
  logic [7:0] err_q;

  // Counts in the same cycle the pulse is generated, so err_cnt and the
  // pulse appear together on the outputs.
  always_ff @(posedge clk) begin
    if (clear)                                 err_q <= '0;
    else if ((ill_d || se_d) && err_q != 8'hFF) err_q <= err_q + 8'd1;
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = 8'd0;
`endif

endmodule
